// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch-stage PC generator.
//
// Selects the next fetch PC from four sources, in priority order:
// MEM correction > EX correction > ID predicted-taken > sequential.
// Drives the instruction-memory request handshake and issues IF/ID flush
// pulses. A redirect that cannot be applied immediately is held in a
// pending register. This happens when the fetch is not completing this
// cycle (WAIT, imem_ready=0, or stall=1). The pending redirect is applied
// when the fetch completes.
//
// Ports:
//   clk, rst           pipeline clock, synchronous active-high reset
//   stall              downstream hold (pc and state frozen, if_valid=0)
//   imem_req/addr      fetch request valid / address (addr == pc)
//   imem_ready         fetch accepted and instruction returned this cycle
//   id_predict_*       ID-stage predicted-taken redirect
//   correct_ex[_pc]    EX-stage misprediction correction
//   correct_mem[_pc]   MEM-stage misprediction correction
//   pc                 current fetch PC
//   if_valid           instruction at pc is valid for ID this cycle
//   flush_if/flush_id  kill IF / ID instruction (combinational)
//
// Optional feature: define PC_REDIRECT_STATS_EN to add three saturating
// counters of applied redirects: stat_predict_cnt, stat_ex_cnt and
// stat_mem_cnt.

module fetch_pc_gen #(
   parameter int                 XLEN       = 32,
   parameter logic [XLEN-1:0]    RESET_PC   = '0,
   parameter int                 INST_BYTES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   output logic             imem_req,
   output logic [XLEN-1:0]  imem_addr,
   input  logic             imem_ready,
   input  logic             id_predict_taken,
   input  logic [XLEN-1:0]  id_predict_target,
   input  logic             correct_ex,
   input  logic [XLEN-1:0]  correct_ex_pc,
   input  logic             correct_mem,
   input  logic [XLEN-1:0]  correct_mem_pc,
   output logic [XLEN-1:0]  pc,
`ifdef PC_REDIRECT_STATS_EN
   output logic [XLEN-1:0]  stat_predict_cnt,
   output logic [XLEN-1:0]  stat_ex_cnt,
   output logic [XLEN-1:0]  stat_mem_cnt,
`endif
   output logic             if_valid,
   output logic             flush_if,
   output logic             flush_id
);

   typedef enum logic [1:0] {ST_RESET, ST_FETCH, ST_WAIT} state_t;

   // Redirect priority levels. A larger value means an older instruction,
   // so it wins.
   localparam logic [1:0] LVL_NONE = 2'd0;
   localparam logic [1:0] LVL_PRED = 2'd1;
   localparam logic [1:0] LVL_EX   = 2'd2;
   localparam logic [1:0] LVL_MEM  = 2'd3;

   localparam logic [XLEN-1:0] INC = XLEN'(INST_BYTES);

   state_t            state_reg, state_next;
   logic [XLEN-1:0]   pc_reg, pc_next;
   logic [1:0]        pend_lvl_reg, pend_lvl_next;
   logic [XLEN-1:0]   pend_tgt_reg, pend_tgt_next;

   logic [1:0]        cur_lvl;
   logic [XLEN-1:0]   cur_tgt;
   logic [1:0]        eff_lvl;
   logic [XLEN-1:0]   eff_tgt;
   logic              fire;
   logic              active;

   // Highest-priority redirect presented this cycle.
   always_comb begin
      cur_lvl = LVL_NONE;
      cur_tgt = '0;
      if (correct_mem) begin
         cur_lvl = LVL_MEM;
         cur_tgt = correct_mem_pc;
      end else if (correct_ex) begin
         cur_lvl = LVL_EX;
         cur_tgt = correct_ex_pc;
      end else if (id_predict_taken) begin
         cur_lvl = LVL_PRED;
         cur_tgt = id_predict_target;
      end
   end

   // Merge the new redirect with the pending one. A new redirect of equal
   // or higher priority replaces the pending one. A lower-priority one is
   // dropped because it belongs to a path that the pending redirect kills.
   always_comb begin
      if (cur_lvl != LVL_NONE && cur_lvl >= pend_lvl_reg) begin
         eff_lvl = cur_lvl;
         eff_tgt = cur_tgt;
      end else begin
         eff_lvl = pend_lvl_reg;
         eff_tgt = pend_tgt_reg;
      end
   end

   assign active = (state_reg == ST_FETCH) || (state_reg == ST_WAIT);
   assign fire   = active && imem_ready && !stall;

   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      pend_lvl_next = eff_lvl;
      pend_tgt_next = eff_tgt;
      if_valid      = 1'b0;
      case (state_reg)
         ST_RESET: begin
            state_next = ST_FETCH;
         end
         ST_FETCH, ST_WAIT: begin
            if (!stall) begin
               if (imem_ready) begin
                  state_next    = ST_FETCH;
                  pc_next       = (eff_lvl != LVL_NONE) ? eff_tgt : pc_reg + INC;
                  pend_lvl_next = LVL_NONE;
                  pend_tgt_next = '0;
                  // A correction applied in FETCH means the instruction just
                  // fetched is on the wrong path.
                  if_valid = (state_reg == ST_WAIT) || (eff_lvl < LVL_EX);
               end else begin
                  state_next = ST_WAIT;
               end
            end
         end
         default: begin
            state_next = ST_RESET;
         end
      endcase
      if (rst) begin
         if_valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_RESET;
         pc_reg       <= RESET_PC;
         pend_lvl_reg <= LVL_NONE;
         pend_tgt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         pend_lvl_reg <= pend_lvl_next;
         pend_tgt_reg <= pend_tgt_next;
      end
   end

   assign pc        = pc_reg;
   assign imem_addr = pc_reg;
   assign imem_req  = active;
   assign flush_if  = !rst && (correct_mem || correct_ex || id_predict_taken);
   assign flush_id  = !rst && (correct_mem || correct_ex);

`ifdef PC_REDIRECT_STATS_EN
   logic [XLEN-1:0] pred_cnt_reg, ex_cnt_reg, mem_cnt_reg;

   // Counted when the redirect is applied to pc, not when it is latched.
   always_ff @(posedge clk) begin
      if (rst) begin
         pred_cnt_reg <= '0;
         ex_cnt_reg   <= '0;
         mem_cnt_reg  <= '0;
      end else if (fire) begin
         case (eff_lvl)
            LVL_PRED: if (pred_cnt_reg != '1) pred_cnt_reg <= pred_cnt_reg + XLEN'(1);
            LVL_EX:   if (ex_cnt_reg   != '1) ex_cnt_reg   <= ex_cnt_reg   + XLEN'(1);
            LVL_MEM:  if (mem_cnt_reg  != '1) mem_cnt_reg  <= mem_cnt_reg  + XLEN'(1);
            default:  ;
         endcase
      end
   end

   assign stat_predict_cnt = pred_cnt_reg;
   assign stat_ex_cnt      = ex_cnt_reg;
   assign stat_mem_cnt     = mem_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
module tb_fetch_pc_gen;

   logic        clk = 1'b0;
   logic        rst, stall, imem_ready;
   logic        id_predict_taken, correct_ex, correct_mem;
   logic [31:0] id_predict_target, correct_ex_pc, correct_mem_pc;

   logic        req1, valid1, fif1, fid1;
   logic [31:0] addr1, pc1;
   logic        req2, valid2, fif2, fid2;
   logic [31:0] addr2, pc2;
`ifdef PC_REDIRECT_STATS_EN
   logic [31:0] sp1, se1, sm1, sp2, se2, sm2;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fetch_pc_gen #(.XLEN(32), .RESET_PC(32'h0000_0000), .INST_BYTES(4)) u1 (
      .clk(clk), .rst(rst), .stall(stall),
      .imem_req(req1), .imem_addr(addr1), .imem_ready(imem_ready),
      .id_predict_taken(id_predict_taken), .id_predict_target(id_predict_target),
      .correct_ex(correct_ex), .correct_ex_pc(correct_ex_pc),
      .correct_mem(correct_mem), .correct_mem_pc(correct_mem_pc),
      .pc(pc1),
`ifdef PC_REDIRECT_STATS_EN
      .stat_predict_cnt(sp1), .stat_ex_cnt(se1), .stat_mem_cnt(sm1),
`endif
      .if_valid(valid1), .flush_if(fif1), .flush_id(fid1)
   );

   fetch_pc_gen #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .INST_BYTES(4)) u2 (
      .clk(clk), .rst(rst), .stall(stall),
      .imem_req(req2), .imem_addr(addr2), .imem_ready(imem_ready),
      .id_predict_taken(id_predict_taken), .id_predict_target(id_predict_target),
      .correct_ex(correct_ex), .correct_ex_pc(correct_ex_pc),
      .correct_mem(correct_mem), .correct_mem_pc(correct_mem_pc),
      .pc(pc2),
`ifdef PC_REDIRECT_STATS_EN
      .stat_predict_cnt(sp2), .stat_ex_cnt(se2), .stat_mem_cnt(sm2),
`endif
      .if_valid(valid2), .flush_if(fif2), .flush_id(fid2)
   );

   typedef struct {
      logic        stall;
      logic        rdy;
      logic        pt;
      logic [31:0] ptgt;
      logic        cex;
      logic [31:0] cexpc;
      logic        cmem;
      logic [31:0] cmempc;
      logic [31:0] epc;
      logic        ereq;
      logic        eval;
      logic        efif;
      logic        efid;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic st, input logic rd,
                      input logic pt, input logic [31:0] ptgt,
                      input logic cx, input logic [31:0] cxpc,
                      input logic cm, input logic [31:0] cmpc,
                      input logic [31:0] epc, input logic ereq, input logic eval,
                      input logic efif, input logic efid);
      vec_t v;
      v.stall = st; v.rdy = rd; v.pt = pt; v.ptgt = ptgt;
      v.cex = cx; v.cexpc = cxpc; v.cmem = cm; v.cmempc = cmpc;
      v.epc = epc; v.ereq = ereq; v.eval = eval; v.efif = efif; v.efid = efid;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      stall = 0; imem_ready = 0;
      id_predict_taken = 0; id_predict_target = 0;
      correct_ex = 0; correct_ex_pc = 0;
      correct_mem = 0; correct_mem_pc = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1;
      clear_inputs();
      imem_ready = 1;

      //   st rdy pt tgt           cex pc           cmem pc          exp_pc        req val fif fid
      // Reset release, then sequential fetch.
      add(0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h000, 0, 0, 0, 0);
      add(0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h000, 1, 1, 0, 0);
      add(0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h004, 1, 1, 0, 0);
      add(0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h008, 1, 1, 0, 0);
      add(0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h00C, 1, 1, 0, 0);
      // ID prediction at 0x10.
      add(0, 1, 1, 32'h80,  0, 32'h0,   0, 32'h0,   32'h010, 1, 1, 1, 0);
      add(0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h080, 1, 1, 0, 0);
      add(0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h084, 1, 1, 0, 0);
      // All three redirects together: MEM wins.
      add(0, 1, 1, 32'h80,  1, 32'h200, 1, 32'h300, 32'h088, 1, 0, 1, 1);
      add(0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h300, 1, 1, 0, 0);
      // WAIT: a pending EX correction is not replaced by a later prediction.
      add(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h304, 1, 0, 0, 0);
      add(0, 0, 0, 32'h0,   1, 32'h40,  0, 32'h0,   32'h304, 1, 0, 1, 1);
      add(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h304, 1, 0, 0, 0);
      add(0, 0, 1, 32'h90,  0, 32'h0,   0, 32'h0,   32'h304, 1, 0, 1, 0);
      add(0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h304, 1, 1, 0, 0);
      // Move to 0x20 with an EX correction.
      add(0, 1, 0, 32'h0,   1, 32'h20,  0, 32'h0,   32'h040, 1, 0, 1, 1);
      // Stall for 3 cycles while a MEM correction pulses.
      add(1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h500, 32'h020, 1, 0, 1, 1);
      add(1, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h020, 1, 0, 0, 0);
      add(1, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h020, 1, 0, 0, 0);
      add(0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h020, 1, 0, 0, 0);
      add(0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h500, 1, 1, 0, 0);
      // Equal-priority pending prediction is replaced by the later one.
      add(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h504, 1, 0, 0, 0);
      add(0, 0, 1, 32'h100, 0, 32'h0,   0, 32'h0,   32'h504, 1, 0, 1, 0);
      add(0, 0, 1, 32'h200, 0, 32'h0,   0, 32'h0,   32'h504, 1, 0, 1, 0);
      add(0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h504, 1, 1, 0, 0);
      // EX correction beats a simultaneous prediction.
      add(0, 1, 1, 32'h80,  1, 32'h600, 0, 32'h0,   32'h200, 1, 0, 1, 1);
      add(0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h600, 1, 1, 0, 0);

      step();
      rst = 0;
      foreach (vq[i]) begin
         stall = vq[i].stall; imem_ready = vq[i].rdy;
         id_predict_taken = vq[i].pt; id_predict_target = vq[i].ptgt;
         correct_ex = vq[i].cex; correct_ex_pc = vq[i].cexpc;
         correct_mem = vq[i].cmem; correct_mem_pc = vq[i].cmempc;
         @(negedge clk);
         chk($sformatf("v%0d pc", i), pc1, vq[i].epc);
         chk($sformatf("v%0d addr", i), addr1, vq[i].epc);
         chk($sformatf("v%0d imem_req", i), {31'b0, req1}, {31'b0, vq[i].ereq});
         chk($sformatf("v%0d if_valid", i), {31'b0, valid1}, {31'b0, vq[i].eval});
         chk($sformatf("v%0d flush_if", i), {31'b0, fif1}, {31'b0, vq[i].efif});
         chk($sformatf("v%0d flush_id", i), {31'b0, fid1}, {31'b0, vq[i].efid});
         $display("vec %0d pc=%h req=%b valid=%b fif=%b fid=%b", i, pc1, req1, valid1, fif1, fid1);
         step();
      end

      // PC wrap with RESET_PC near the top of the address space, then a
      // reset that must drop a pending redirect.
      clear_inputs();
      rst = 1; imem_ready = 1;
      step();
      rst = 0;
      @(negedge clk); chk("wrap reset pc", pc2, 32'hFFFF_FFF8);
      chk("wrap reset req", {31'b0, req2}, 32'd0);
      $display("wrap pc=%h req=%b", pc2, req2);
      step();
      @(negedge clk); chk("wrap pc0", pc2, 32'hFFFF_FFF8);
      chk("wrap valid0", {31'b0, valid2}, 32'd1);
      $display("wrap pc=%h valid=%b", pc2, valid2);
      step();
      @(negedge clk); chk("wrap pc1", pc2, 32'hFFFF_FFFC);
      $display("wrap pc=%h", pc2);
      step();
      @(negedge clk); chk("wrap pc2", pc2, 32'h0000_0000);
      $display("wrap pc=%h", pc2);
      step();
      stall = 1; correct_mem = 1; correct_mem_pc = 32'h700;
      @(negedge clk); chk("pend pc", pc2, 32'h0000_0004);
      chk("pend valid", {31'b0, valid2}, 32'd0);
      chk("pend flush_id", {31'b0, fid2}, 32'd1);
      $display("pend pc=%h fid=%b", pc2, fid2);
      step();
      correct_mem = 0;
      @(negedge clk); chk("pend hold pc", pc2, 32'h0000_0004);
      step();
      rst = 1; stall = 0;
      @(negedge clk); chk("rst valid", {31'b0, valid2}, 32'd0);
      step();
      rst = 0;
      @(negedge clk); chk("rerst pc", pc2, 32'hFFFF_FFF8);
      chk("rerst req", {31'b0, req2}, 32'd0);
      $display("rerst pc=%h req=%b", pc2, req2);
      step();
      @(negedge clk); chk("rerst pc0", pc2, 32'hFFFF_FFF8);
      step();
      @(negedge clk); chk("rerst no pending", pc2, 32'hFFFF_FFFC);
      $display("rerst pc=%h", pc2);
      step();
      @(negedge clk); chk("rerst pc2", pc2, 32'h0000_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Fetch-stage PC generator. Sits directly upstream of the ID-stage branch predictor.
- Every cycle it chooses the next fetch PC from four sources:
  - the sequential PC;
  - the ID-stage predicted-taken redirect;
  - the EX-stage misprediction correction;
  - the MEM-stage misprediction correction.
- It drives the instruction-memory request handshake and issues IF/ID flush pulses.
- Redirects that arrive while a fetch is outstanding are buffered and applied when the fetch completes.

Parameters:
- XLEN, 32, PC width in bits.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- INST_BYTES, 4, sequential PC increment.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  downstream hold; PC must not advance while high.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address; always equals pc.
- imem_ready  in  1  request accepted and instruction returned this cycle.
- id_predict_taken  in  1  ID predictor says taken (the predictBranchAvail net).
- id_predict_target  in  XLEN  target PC for the ID redirect.
- correct_ex  in  1  EX resolved a misprediction.
- correct_ex_pc  in  XLEN  recovery PC from EX.
- correct_mem  in  1  MEM resolved a misprediction.
- correct_mem_pc  in  XLEN  recovery PC from MEM.
- pc  out  XLEN  current fetch PC.
- if_valid  out  1  fetched instruction at pc is valid for ID this cycle.
- flush_if  out  1  kill the instruction in IF.
- flush_id  out  1  kill the instruction in ID.

Behaviour:
- Reset (rst=1 at a clk edge):
  - pc=RESET_PC, state=RESET.
  - imem_req=0, if_valid=0, flush_if=0, flush_id=0.
  - Pending-redirect register cleared.
  - rst wins over every simultaneous input.
  - Asserting reset mid-fetch or while a redirect is pending discards both.
- States:
  - RESET: for one cycle after rst deasserts, imem_req=0. Next state is FETCH.
  - FETCH: imem_req=1.
    - On imem_ready=1 with stall=0: if_valid=1 and pc advances to next_pc (below).
    - On imem_ready=0: next state is WAIT.
  - WAIT: imem_req=1, pc held.
    - On imem_ready=1: if_valid=1.
    - If a redirect is pending, pc=pending target and the pending register is cleared. Otherwise pc=pc+INST_BYTES.
    - Next state is FETCH.
- Redirect priority within a cycle: correct_mem > correct_ex > id_predict_taken > sequential. The older instruction wins.
- next_pc is the highest-priority active source.
  - Sequential PC is pc+INST_BYTES, modulo 2^XLEN. Wrap from 32'hFFFF_FFFC gives 0.
- Redirect taken in FETCH with imem_ready=1:
  - pc loads the target at the next edge.
  - if_valid=0 for the fetched wrong-path instruction in that cycle if the redirect is a correction.
- Redirect asserted while in WAIT, or while stall=1:
  - The target is latched into the pending register together with its priority level.
  - A later redirect replaces the pending one only if its priority is equal or higher.
  - The pending redirect is applied at the first edge with imem_ready=1 and stall=0.
- Flush outputs, combinational from the same cycle's inputs:
  - flush_if = correct_mem | correct_ex | id_predict_taken.
  - flush_id = correct_mem | correct_ex.
  - An ID prediction does not flush ID itself.
- Stall: stall=1 holds pc and state. imem_req stays asserted in FETCH/WAIT. if_valid=0.
- Simultaneous events:
  - correct_ex together with id_predict_taken: the EX correction wins and the predict target is ignored.
  - correct_mem together with correct_ex: the MEM correction wins.
- Latency: a redirect seen in FETCH with imem_ready=1 changes pc at the next clk edge, i.e. one cycle.

Optional Feature:
- Macro PC_REDIRECT_STATS_EN.
- Defined:
  - Three 32-bit saturating counters: stat_predict_cnt, stat_ex_cnt, stat_mem_cnt. Each is an output port of XLEN width.
  - Each counter increments once per applied redirect of its kind. A redirect counts at apply time, not at latch time.
  - Counters are cleared by rst and saturate at 32'hFFFF_FFFF.
- Undefined: the counter ports and logic are absent. Core behaviour is identical.

Test Plan:
1. Reset, then imem_ready=1 for 4 cycles → pc sequence 0x0, 0x4, 0x8, 0xC. if_valid=1 from the second cycle after rst deasserts. All flushes 0.
2. At pc=0x10 with imem_ready=1, pulse id_predict_taken with target 0x80 → next pc=0x80, flush_if=1, flush_id=0, then pc=0x84.
3. Same cycle: correct_ex (pc 0x200), correct_mem (pc 0x300), id_predict_taken (target 0x80) → pc=0x300, flush_if=1, flush_id=1.
4. In WAIT (imem_ready=0), pulse correct_ex with pc 0x40; two cycles later pulse id_predict_taken with target 0x90; then imem_ready=1 → pc=0x40, because the lower-priority predict does not overwrite the pending correction.
5. stall=1 for 3 cycles at pc=0x20 while correct_mem with pc 0x500 pulses → pc holds 0x20, then pc=0x500 on the first edge with stall=0 and imem_ready=1.
6. Set RESET_PC=32'hFFFF_FFF8, imem_ready=1 → pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. Mid-sequence rst → pc returns to RESET_PC and the pending redirect is dropped.
